// File: rtl/shift_pkg.sv
// Shared types and constants for the universal shift register and its helpers.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } shift_mode_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle strobe on wrap.
module shift_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_reg, count_next;
  logic          wrap_reg, wrap_next;
  logic          at_last;

  assign at_last = (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = at_last ? '0 : count_reg + CW'(1);
      // The strobe lands together with the edge that completes the word.
      wrap_next  = at_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;

endmodule

// File: rtl/universal_shift_register.sv
// Width-configurable shift register: hold, shift, load, rotate in either direction,
// with a word-complete strobe so it can act as SIPO deserialiser or PISO serialiser.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     dir,
  input  logic                     serial_in,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     serial_out,
  output logic [WIDTH-1:0]         parallel_out,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     word_valid
);

  shift_mode_t      mode_sel;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] shift_left, shift_right, rot_left, rot_right;
  logic             cnt_inc, cnt_clr;

  assign mode_sel    = shift_mode_t'(mode);
  assign shift_left  = {q_reg[WIDTH-2:0], serial_in};
  assign shift_right = {serial_in, q_reg[WIDTH-1:1]};
  assign rot_left    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign rot_right   = {q_reg[0], q_reg[WIDTH-1:1]};

  always_comb begin
    q_next = q_reg;
    if (en) begin
      case (mode_sel)
        MODE_SHIFT:  q_next = (dir == DIR_RIGHT) ? shift_right : shift_left;
        MODE_LOAD:   q_next = load_data;
        MODE_ROTATE: q_next = (dir == DIR_RIGHT) ? rot_right : rot_left;
        default:     q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  // Disabled cycles neither count nor clear; the strobe drops on its own.
  assign cnt_inc = en && (mode_sel == MODE_SHIFT);
  assign cnt_clr = en && (mode_sel == MODE_LOAD);

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (bit_count),
    .wrap  (word_valid)
  );

  assign serial_out   = (dir == DIR_RIGHT) ? q_reg[0] : q_reg[WIDTH-1];
  assign parallel_out = q_reg;

endmodule
